multdiv_ctrl: RTL and testbench

Sequencer for the multicycle multiply/divide unit attached to the execute stage of the five-stage pipeline. It detects a `mul`/`div` in execute, latches the operands, starts the unit, and freezes fetch/decode/execute until the unit finishes. It then hands the result, or the `$rstatus` exception code, to the X/M latch for exactly one cycle.

---
 rtl/multdiv_ctrl_pkg.sv | 26 ++
 rtl/multdiv_watchdog.sv | 30 +++
 rtl/multdiv_ctrl.sv | 117 +++++++++++
 tb/tb_multdiv_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states and $rstatus codes.
// Build option MULTDIV_TIMEOUT_EN turns on the RUN-state watchdog.
package multdiv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0]  RSTATUS_REG     = 5'd30;
    localparam logic [31:0] RSTATUS_MUL     = 32'd4;
    localparam logic [31:0] RSTATUS_DIV     = 32'd5;
    localparam logic [31:0] RSTATUS_TIMEOUT = 32'd6;

`ifdef MULTDIV_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    function automatic logic [31:0] exception_code(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// RUN-cycle counter with expiry flag; expiry only fires when MULTDIV_TIMEOUT_EN is defined,
// the counter itself is always present.
module multdiv_watchdog
    import multdiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The count starts at 0 in the first RUN cycle, so TIMEOUT_CYCLES-1 marks the last allowed cycle.
    assign expired = TIMEOUT_EN && enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the multicycle mul/div unit: issue, stall, single-cycle writeback.
// MULTDIV_TIMEOUT_EN enables the watchdog that forces completion with $rstatus code 6.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_mul,
    input  logic        ex_is_div,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_operand_a,
    input  logic [31:0] ex_operand_b,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        md_start_mult,
    output logic        md_start_div,
    output logic [31:0] md_data_a,
    output logic [31:0] md_data_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    state_t           state;
    state_t           state_next;
    logic             issue;
    logic             start_cycle;
    logic             accept;
    logic             timeout_hit;
    logic             op_div;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] run_count;
    logic             expired;

    assign issue       = (state == IDLE) && ex_valid && (ex_is_mul || ex_is_div);
    assign start_cycle = md_start_mult || md_start_div;
    // md_ready takes priority over an expiring watchdog in the same cycle.
    assign accept      = (state == RUN) && !start_cycle && md_ready;
    assign timeout_hit = (state == RUN) && !start_cycle && !md_ready && expired;

    assign stall    = issue || (state == RUN);
    assign wb_valid = (state == DONE);

    multdiv_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (issue),
        .enable (state == RUN),
        .count  (run_count),
        .expired(expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (accept || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_start_mult <= 1'b0;
            md_start_div  <= 1'b0;
            md_data_a     <= '0;
            md_data_b     <= '0;
            op_div        <= 1'b0;
            rd_q          <= '0;
            wb_rd         <= '0;
            wb_data       <= '0;
            timeout_err   <= 1'b0;
        end else begin
            md_start_mult <= issue && ex_is_mul;
            md_start_div  <= issue && ex_is_div;
            if (issue) begin
                md_data_a <= ex_operand_a;
                md_data_b <= ex_operand_b;
                op_div    <= ex_is_div;
                rd_q      <= ex_rd;
            end
            if (accept) begin
                if (md_exception) begin
                    wb_rd   <= RSTATUS_REG;
                    wb_data <= exception_code(op_div);
                end else begin
                    wb_rd   <= rd_q;
                    wb_data <= md_result;
                end
            end else if (timeout_hit) begin
                wb_rd       <= RSTATUS_REG;
                wb_data     <= RSTATUS_TIMEOUT;
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: expected writebacks are queued at issue and
// popped by a monitor whenever wb_valid is seen; MULTDIV_TIMEOUT_EN selects the timeout scenario.
module tb_multdiv_ctrl;

    localparam int TIMEOUT_CYCLES = 64;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_is_mul = 1'b0;
    logic        ex_is_div = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_operand_a = '0;
    logic [31:0] ex_operand_b = '0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic [31:0] md_result = '0;
    logic        md_start_mult;
    logic        md_start_div;
    logic [31:0] md_data_a;
    logic [31:0] md_data_b;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] regfile [32];

    multdiv_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (7)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_is_mul    (ex_is_mul),
        .ex_is_div    (ex_is_div),
        .ex_rd        (ex_rd),
        .ex_operand_a (ex_operand_a),
        .ex_operand_b (ex_operand_b),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .md_result    (md_result),
        .md_start_mult(md_start_mult),
        .md_start_div (md_start_div),
        .md_data_a    (md_data_a),
        .md_data_b    (md_data_b),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    // Monitor: every writeback must match the oldest queued expectation.
    always @(negedge clock) begin
        if (wb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL wb_result: got rd=%0d data=%h, expected rd=%0d data=%h",
                             wb_rd, wb_data, e.rd, e.data);
                end
                regfile[wb_rd] = wb_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    task automatic idle_ex();
        @(posedge clock); #1;
        ex_valid  = 1'b0;
        ex_is_mul = 1'b0;
        ex_is_div = 1'b0;
    endtask

    // Issues one op, answers md_ready after k RUN cycles, and ends in the DONE cycle
    // with the instruction still held in execute (so a re-issue would be visible).
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input bit exc,
                          input logic [31:0] result, input bit noise, input string name);
        exp_t e;
        int   stall_cnt;
        int   start_cnt;
        int   wrong_start;
        e.rd   = exc ? 5'd30 : rd;
        e.data = exc ? (is_div ? 32'd5 : 32'd4) : result;
        stall_cnt   = 0;
        start_cnt   = 0;
        wrong_start = 0;
        @(posedge clock); #1;
        ex_valid     = 1'b1;
        ex_is_mul    = !is_div;
        ex_is_div    = is_div;
        ex_rd        = rd;
        ex_operand_a = a;
        ex_operand_b = b;
        sb.push_back(e);
        for (int cyc = 0; cyc <= k + 1; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock); #1;
            end
            md_ready     = (cyc == k + 1) || (noise && cyc <= 1);
            md_exception = (cyc == k + 1) ? exc : noise;
            md_result    = (cyc == k + 1) ? result : 32'hdead_beef;
            @(negedge clock);
            if (stall) stall_cnt++;
            if (is_div ? md_start_div : md_start_mult) start_cnt++;
            if (is_div ? md_start_mult : md_start_div) wrong_start++;
            if (cyc == 1) begin
                checks++;
                if (md_data_a !== a || md_data_b !== b) begin
                    errors++;
                    $display("[TB] FAIL %s operands: got a=%h b=%h, expected a=%h b=%h",
                             name, md_data_a, md_data_b, a, b);
                end
            end
        end
        @(posedge clock); #1;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b1 || stall !== 1'b0 || md_start_mult !== 1'b0 || md_start_div !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: got wb_valid=%b stall=%b starts=%b%b, expected 1 0 00",
                     name, wb_valid, stall, md_start_mult, md_start_div);
        end
        checks++;
        if (stall_cnt != k + 2) begin
            errors++;
            $display("[TB] FAIL %s stall_cycles: got %0d, expected %0d", name, stall_cnt, k + 2);
        end
        checks++;
        if (start_cnt != 1 || wrong_start != 0) begin
            errors++;
            $display("[TB] FAIL %s start_pulse: got %0d matching / %0d other, expected 1 / 0",
                     name, start_cnt, wrong_start);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if ({stall, wb_valid, md_start_mult, md_start_div, timeout_err, wb_rd, wb_data, md_data_a, md_data_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got stall=%b wb_valid=%b wb_rd=%0d wb_data=%h a=%h b=%h terr=%b, expected all 0",
                     stall, wb_valid, wb_rd, wb_data, md_data_a, md_data_b, timeout_err);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mul();
        run_op(1'b0, 32'd3, 32'd7, 5'd5, 16, 1'b0, 32'd21, 1'b0, "mul");
        idle_ex();
        checks++;
        if (regfile[5] !== 32'd21) begin
            errors++;
            $display("[TB] FAIL mul_reg5: got %h, expected %h", regfile[5], 32'd21);
        end
    endtask

    task automatic test_div_by_zero();
        run_op(1'b1, 32'd10, 32'd0, 5'd9, 33, 1'b1, 32'hffff_ffff, 1'b0, "div0");
        idle_ex();
        checks++;
        if (regfile[30] !== 32'd5) begin
            errors++;
            $display("[TB] FAIL div0_reg30: got %h, expected %h", regfile[30], 32'd5);
        end
    endtask

    // md_ready/md_exception noise in IDLE and the start-pulse cycle must be ignored.
    task automatic test_mul_overflow_then_add();
        run_op(1'b0, 32'h4000_0000, 32'd4, 5'd7, 3, 1'b1, 32'h0, 1'b1, "mul_ovf");
        @(posedge clock); #1;
        ex_valid  = 1'b1;
        ex_is_mul = 1'b0;
        ex_is_div = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (stall !== 1'b0 || md_start_mult !== 1'b0 || md_start_div !== 1'b0) begin
                errors++;
                $display("[TB] FAIL add_after_mul[%0d]: got stall=%b starts=%b%b, expected 0 00",
                         i, stall, md_start_mult, md_start_div);
            end
            @(posedge clock); #1;
        end
        ex_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 32'd6, 32'd7, 5'd3, 2, 1'b0, 32'd42, 1'b0, "b2b_1");
        run_op(1'b0, 32'd100, 32'd200, 5'd0, 1, 1'b0, 32'd20000, 1'b0, "b2b_2");
        run_op(1'b1, 32'd50, 32'd5, 5'd12, 4, 1'b0, 32'd10, 1'b0, "b2b_3");
        idle_ex();
    endtask

    task automatic test_ready_at_watchdog();
        run_op(1'b0, 32'd9, 32'd9, 5'd17, TIMEOUT_CYCLES - 1, 1'b0, 32'd81, 1'b0, "ready_wd");
        idle_ex();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_wd_terr: got %b, expected 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_activity;
        saw_activity = 1'b0;
        @(posedge clock); #1;
        ex_valid     = 1'b1;
        ex_is_mul    = 1'b1;
        ex_rd        = 5'd11;
        ex_operand_a = 32'h1111_2222;
        ex_operand_b = 32'h3333_4444;
        repeat (5) @(posedge clock);
        #3;
        reset     = 1'b0;
        ex_valid  = 1'b0;
        ex_is_mul = 1'b0;
        #1;
        checks++;
        if ({stall, wb_valid, md_start_mult, md_start_div, timeout_err, wb_rd, wb_data, md_data_a, md_data_b} !== '0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_outputs: got stall=%b wb_rd=%0d wb_data=%h a=%h b=%h, expected all 0",
                     stall, wb_rd, wb_data, md_data_a, md_data_b);
        end
        checks++;
        if (dut.state !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset_state: got %0d, expected 0", dut.state);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        md_ready  = 1'b1;
        md_result = 32'd77;
        @(posedge clock); #1;
        md_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (wb_valid || stall) saw_activity = 1'b1;
        end
        checks++;
        if (saw_activity) begin
            errors++;
            $display("[TB] FAIL midrun_late_ready: got wb_valid/stall activity, expected none");
        end
    endtask

`ifdef MULTDIV_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int   stall_cnt;
        int   done_cyc;
        e.rd      = 5'd30;
        e.data    = 32'd6;
        stall_cnt = 0;
        done_cyc  = -1;
        @(posedge clock); #1;
        ex_valid  = 1'b1;
        ex_is_mul = 1'b1;
        ex_rd     = 5'd4;
        sb.push_back(e);
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock); #1;
            end
            @(negedge clock);
            if (wb_valid) begin
                done_cyc = cyc;
                break;
            end
            if (stall) stall_cnt++;
        end
        checks++;
        if (done_cyc != TIMEOUT_CYCLES + 1 || stall_cnt != TIMEOUT_CYCLES + 1) begin
            errors++;
            $display("[TB] FAIL timeout_done: got done at %0d stall %0d, expected %0d and %0d",
                     done_cyc, stall_cnt, TIMEOUT_CYCLES + 1, TIMEOUT_CYCLES + 1);
        end
        idle_ex();
        repeat (3) @(negedge clock);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got %b, expected 1", timeout_err);
        end
    endtask
`else
    task automatic test_timeout();
        exp_t e;
        @(posedge clock); #1;
        ex_valid     = 1'b1;
        ex_is_mul    = 1'b1;
        ex_rd        = 5'd4;
        ex_operand_a = 32'd1;
        ex_operand_b = 32'd2;
        repeat (200) @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (stall !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_timeout: got stall=%b timeout_err=%b, expected 1 0", stall, timeout_err);
        end
        @(posedge clock); #1;
        e.rd   = 5'd4;
        e.data = 32'd2;
        sb.push_back(e);
        md_ready  = 1'b1;
        md_result = 32'd2;
        @(posedge clock); #1;
        md_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_timeout_done: got wb_valid=%b, expected 1", wb_valid);
        end
        idle_ex();
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = '0;
        test_reset();
        test_mul();
        test_div_by_zero();
        test_mul_overflow_then_add();
        test_back_to_back();
        test_ready_at_watchdog();
        test_reset_mid_run();
        test_timeout();
        repeat (2) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
